hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter STALL_CNT_W, default 16, width of the stall/flush performance counters.
REQ-002 Port clk  input  1  pipeline clock; all state changes on its rising edge.
REQ-003 Port rst  input  1  synchronous, active-high reset.
REQ-004 Port ID_Opcode  input  6  opcode of the instruction in ID.
REQ-005 Port ID_Rs, ID_Rt  input  5 each  source register fields of the instruction in ID.
REQ-006 Port ID_Branch, ID_Jump  input  1 each  decoded branch/jump in ID.
REQ-007 Port branch_taken  input  1  branch resolved taken in ID this cycle.
REQ-008 Port EX_MemRead, EX_RegWrite  input  1 each; EX_WriteReg  input  5  destination in EX.
REQ-009 Port MEM_MemRead  input  1; MEM_WriteReg  input  5  destination of the load in MEM.
REQ-010 Port ICACHE_stall, DCACHE_stall  input  1 each  memory not ready; level-held until ready.
REQ-011 Port PC_write, IFID_write  output  1 each  enable PC and IF/ID update.
REQ-012 Port stall  output  1  bubble request to the ID control mux (zeroes ID controls).
REQ-013 Port IFID_flush  output  1  squash the IF/ID instruction.
REQ-014 Port freeze  output  1  hold the ID/EX, EX/MEM and MEM/WB registers.

Function
REQ-015 The block SHALL use a 3-state FSM: RUN, STALL, FREEZE.
REQ-016 The block SHALL define "ID uses rt" as ID_Opcode in {0x00, 0x04, 0x05, 0x2B}; a match on register 0 SHALL never count as a hazard.
REQ-017 need SHALL be 2 if ID_Branch and EX_MemRead and EX_WriteReg matches a used source.
REQ-018 Otherwise need SHALL be 1 if (EX_MemRead and a match) or (ID_Branch and EX_RegWrite and an EX match) or (ID_Branch and MEM_MemRead and a MEM match); otherwise 0.
REQ-019 In RUN with need>0, the block SHALL assert stall, deassert PC_write and IFID_write in the same cycle, load the counter with need-1, and go to STALL if need-1>0.
REQ-020 In STALL, the block SHALL keep stall asserted and PC_write/IFID_write low, decrement the counter each cycle, and return to RUN after the cycle in which the counter is 0.
REQ-021 In RUN with need=0 and (branch_taken or ID_Jump), the block SHALL assert IFID_flush for exactly that cycle, with PC_write=1.
REQ-022 ICACHE_stall or DCACHE_stall SHALL take priority in every state: freeze=1, PC_write=0, IFID_write=0, stall=0, IFID_flush=0, and the next state SHALL be FREEZE.
REQ-023 On entering FREEZE, the block SHALL save the interrupted state and counter; both SHALL be restored on the first cycle with both cache stalls low. The counter SHALL not decrement while frozen.
REQ-024 In RUN with no hazard, no flush and no freeze: PC_write=1, IFID_write=1, and all other outputs SHALL be 0.
REQ-025 A hazard detected together with branch_taken SHALL give the stall priority, and the flush SHALL be suppressed that cycle.

Reset
REQ-026 With rst=1 at a clock edge, the state SHALL become RUN and the counter and saved state SHALL clear, including mid-STALL or mid-FREEZE.
REQ-027 During rst, outputs SHALL be PC_write=0, IFID_write=0, stall=1, IFID_flush=1 and freeze=0.

Configuration
REQ-028 With macro HAZARD_PERF_CNT_EN defined, the block SHALL add the outputs stall_cycles and flush_count (each STALL_CNT_W bits).
REQ-029 stall_cycles SHALL increment on every cycle with stall=1, and flush_count SHALL increment on every cycle with IFID_flush=1. Both SHALL saturate and clear on rst.
REQ-030 With HAZARD_PERF_CNT_EN undefined, these ports and counters SHALL be absent and the behaviour SHALL otherwise be identical.

Structure
REQ-031 The FSM state encoding and the opcode constants (R-type 0x00, BEQ 0x04, BNE 0x05, SW 0x2B) SHALL live in the shared pipeline package.
REQ-032 The need computation SHALL be one sub-module, hazard_detect, which is purely combinational. The FSM, counter and optional perf counters SHALL remain in hazard_ctrl.

Verification
REQ-033 Load-use: EX_MemRead=1, EX_WriteReg=5, ID_Rs=5, opcode 0x00 -> stall=1 and PC_write=0 for exactly 1 cycle.
REQ-034 Branch after load: ID_Branch=1, opcode 0x04, EX_MemRead=1, EX_WriteReg=ID_Rt=7 -> stall for 2 consecutive cycles, then RUN.
REQ-035 Register 0: EX_MemRead=1, EX_WriteReg=0, ID_Rs=0 -> no stall.
REQ-036 Taken branch: branch_taken=1 with no hazard -> IFID_flush=1 for 1 cycle; flush_count goes 0->1 when HAZARD_PERF_CNT_EN is defined.
REQ-037 Freeze mid-stall: DCACHE_stall=1 for 3 cycles during the first STALL cycle of REQ-034 -> freeze=1 for 3 cycles, then 1 remaining stall cycle.
REQ-038 Reset in FREEZE: rst=1 for 1 cycle -> state RUN; with no hazard, the next cycle shows PC_write=1 and freeze=0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline package: hazard FSM state encoding, the opcodes that read rt,
// and the width of the internal stall counter.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        FREEZE = 2'd2
    } hz_state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // The largest bubble request is 2, so the remaining-cycles counter holds 0..1.
    localparam int CNT_W = 2;

    // True when the ID instruction actually reads its rt field as a source.
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Purely combinational hazard detector: how many bubble cycles the ID
// instruction needs before its operands are available (0, 1 or 2).
module hazard_detect
    import hazard_ctrl_pkg::*;
(
    input  logic [5:0] ID_Opcode,
    input  logic [4:0] ID_Rs,
    input  logic [4:0] ID_Rt,
    input  logic       ID_Branch,
    input  logic       EX_MemRead,
    input  logic       EX_RegWrite,
    input  logic [4:0] EX_WriteReg,
    input  logic       MEM_MemRead,
    input  logic [4:0] MEM_WriteReg,
    output logic [1:0] need
);

    logic rt_used;
    logic ex_match;
    logic mem_match;

    // Register 0 is hard-wired, so a match on it never creates a dependency.
    always_comb begin
        rt_used   = uses_rt(ID_Opcode);
        ex_match  = ((ID_Rs != 5'd0) && (ID_Rs == EX_WriteReg)) ||
                    (rt_used && (ID_Rt != 5'd0) && (ID_Rt == EX_WriteReg));
        mem_match = ((ID_Rs != 5'd0) && (ID_Rs == MEM_WriteReg)) ||
                    (rt_used && (ID_Rt != 5'd0) && (ID_Rt == MEM_WriteReg));
        need = 2'd0;
        if (ID_Branch && EX_MemRead && ex_match) begin
            need = 2'd2;
        end else if ((EX_MemRead && ex_match) ||
                     (ID_Branch && EX_RegWrite && ex_match) ||
                     (ID_Branch && MEM_MemRead && mem_match)) begin
            need = 2'd1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: RUN/STALL/FREEZE FSM driving PC/IF-ID enables,
// the ID bubble mux, IF/ID squash and the back-end freeze.
// Optional feature macro: HAZARD_PERF_CNT_EN adds saturating stall_cycles and
// flush_count performance counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int STALL_CNT_W = 16
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] ID_Opcode,
    input  logic [4:0] ID_Rs,
    input  logic [4:0] ID_Rt,
    input  logic       ID_Branch,
    input  logic       ID_Jump,
    input  logic       branch_taken,
    input  logic       EX_MemRead,
    input  logic       EX_RegWrite,
    input  logic [4:0] EX_WriteReg,
    input  logic       MEM_MemRead,
    input  logic [4:0] MEM_WriteReg,
    input  logic       ICACHE_stall,
    input  logic       DCACHE_stall,
    output logic       PC_write,
    output logic       IFID_write,
    output logic       stall,
    output logic       IFID_flush,
`ifdef HAZARD_PERF_CNT_EN
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic [STALL_CNT_W-1:0] flush_count,
`endif
    output logic       freeze
);

    hz_state_t        state, saved_state, cur_state, state_nx, saved_state_nx;
    logic [CNT_W-1:0] cnt, saved_cnt, cur_cnt, cnt_nx, saved_cnt_nx;
    logic [1:0]       need;
    logic             cache_stall;

    hazard_detect u_detect (
        .ID_Opcode    (ID_Opcode),
        .ID_Rs        (ID_Rs),
        .ID_Rt        (ID_Rt),
        .ID_Branch    (ID_Branch),
        .EX_MemRead   (EX_MemRead),
        .EX_RegWrite  (EX_RegWrite),
        .EX_WriteReg  (EX_WriteReg),
        .MEM_MemRead  (MEM_MemRead),
        .MEM_WriteReg (MEM_WriteReg),
        .need         (need)
    );

    assign cache_stall = ICACHE_stall | DCACHE_stall;

    // While frozen, the interrupted state/counter are what resume once the caches are ready.
    assign cur_state = (state == FREEZE) ? saved_state : state;
    assign cur_cnt   = (state == FREEZE) ? saved_cnt   : cnt;

    // Outputs and next state: reset, then cache freeze, then ongoing stall, then new hazard, then flush.
    always_comb begin
        state_nx       = cur_state;
        cnt_nx         = cur_cnt;
        saved_state_nx = saved_state;
        saved_cnt_nx   = saved_cnt;
        PC_write       = 1'b1;
        IFID_write     = 1'b1;
        stall          = 1'b0;
        IFID_flush     = 1'b0;
        freeze         = 1'b0;
        if (rst) begin
            PC_write   = 1'b0;
            IFID_write = 1'b0;
            stall      = 1'b1;
            IFID_flush = 1'b1;
        end else if (cache_stall) begin
            PC_write       = 1'b0;
            IFID_write     = 1'b0;
            freeze         = 1'b1;
            state_nx       = FREEZE;
            cnt_nx         = cnt;
            saved_state_nx = cur_state;
            saved_cnt_nx   = cur_cnt;
        end else if (cur_state == STALL) begin
            PC_write   = 1'b0;
            IFID_write = 1'b0;
            stall      = 1'b1;
            cnt_nx     = (cur_cnt == '0) ? '0 : cur_cnt - CNT_W'(1);
            state_nx   = (cur_cnt <= CNT_W'(1)) ? RUN : STALL;
        end else if (need != 2'd0) begin
            PC_write   = 1'b0;
            IFID_write = 1'b0;
            stall      = 1'b1;
            cnt_nx     = need - 2'd1;
            state_nx   = (need > 2'd1) ? STALL : RUN;
        end else if (branch_taken || ID_Jump) begin
            IFID_flush = 1'b1;
        end
    end

    // State, counter and saved context registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            cnt         <= '0;
            saved_state <= RUN;
            saved_cnt   <= '0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            saved_state <= saved_state_nx;
            saved_cnt   <= saved_cnt_nx;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Saturating counts of bubble cycles and IF/ID squashes.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + STALL_CNT_W'(1);
            end
            if (IFID_flush && (flush_count != '1)) begin
                flush_count <= flush_count + STALL_CNT_W'(1);
            end
        end
    end
`endif

endmodule
